sprite_blit: RTL

//  Copies one 8x8 sprite from the sprite ROM into the 640x480 framebuffer.
//  A single start request carries an anchor address (bottom-left pixel) and a sprite id.
//  The block steps a 6-bit pixel counter 0..63, turns each count into a framebuffer

---
 rtl/sprite_pkg.sv | 23 ++
 rtl/sprite_blit_if.sv | 35 +++
 rtl/sprite_blit_addr.sv | 18 +
 rtl/sprite_blit.sv | 122 ++++++++++++
 4 files changed

// File: rtl/sprite_pkg.sv
// sprite_pkg: shared constants and types for the sprite blitter slice.
//   SCREEN_W   framebuffer row pitch in pixels
//   SPRITE_DIM sprite edge length in pixels
//   SPRITE_PIX pixels per sprite
//   state_t    blitter FSM states
package sprite_pkg;

   localparam int unsigned SCREEN_W   = 640;
   localparam int unsigned SPRITE_DIM = 8;
   localparam int unsigned SPRITE_PIX = SPRITE_DIM * SPRITE_DIM;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FETCH = 2'd1,
      WRITE = 2'd2,
      DONE  = 2'd3
   } state_t;

   typedef logic [18:0] pixel_addr_t;
   typedef logic [5:0]  pix_cnt_t;
   typedef logic [7:0]  colour_t;

endpackage

// File: rtl/sprite_blit_if.sv
// sprite_blit_if: scheduler request, sprite ROM and framebuffer write port
// of the sprite blitter.
//   start/coordinates/sprite_id  request from the sprite scheduler
//   busy/done                    status back to the scheduler
//   rom_addr/rom_data            sprite ROM read port
//   fb_addr/fb_data/fb_we/fb_ready framebuffer write port
// Modports: master = environment (scheduler, ROM, framebuffer), slave = blitter.
interface sprite_blit_if
   import sprite_pkg::*;
#(
   parameter int unsigned ID_W  = 4,
   parameter int unsigned PIX_W = 8
);
   logic              start;
   pixel_addr_t       coordinates;
   logic [ID_W-1:0]   sprite_id;
   logic              busy;
   logic              done;
   logic [ID_W+5:0]   rom_addr;
   logic [PIX_W-1:0]  rom_data;
   pixel_addr_t       fb_addr;
   logic [PIX_W-1:0]  fb_data;
   logic              fb_we;
   logic              fb_ready;

   modport master (
      output start, coordinates, sprite_id, rom_data, fb_ready,
      input  busy, done, rom_addr, fb_addr, fb_data, fb_we
   );

   modport slave (
      input  start, coordinates, sprite_id, rom_data, fb_ready,
      output busy, done, rom_addr, fb_addr, fb_data, fb_we
   );
endinterface

// File: rtl/sprite_blit_addr.sv
// sprite_addr: combinational framebuffer address generator.
//   coordinates  anchor address (bottom-left pixel) of the sprite
//   counter      pixel index 0..63, row = counter[5:3], column = counter[2:0]
//   addr         coordinates - row*SCREEN_W + column (19-bit wrap)
//   row_off      row*SCREEN_W, exposed so the caller can clip rows above the screen
module sprite_addr
   import sprite_pkg::*;
(
   input  pixel_addr_t coordinates,
   input  pix_cnt_t    counter,
   output pixel_addr_t addr,
   output pixel_addr_t row_off
);
   always_comb begin
      row_off = pixel_addr_t'(counter[5:3]) * pixel_addr_t'(SCREEN_W);
      addr    = coordinates - row_off + pixel_addr_t'(counter[2:0]);
   end
endmodule

// File: rtl/sprite_blit.sv
// sprite_blit: copies one 8x8 sprite from the sprite ROM into the framebuffer.
//   clk, rst   rising-edge clock, asynchronous active-high reset
//   bus        sprite_blit_if.slave: request/status, ROM read, framebuffer write
// Rows above the top of the screen are skipped without a write.
// Optional build macro SPRITE_BLIT_TRANSPARENCY_EN: pixels equal to
// TRANSPARENT are skipped like clipped pixels.
module sprite_blit
   import sprite_pkg::*;
#(
   parameter int unsigned          ID_W        = 4,
   parameter int unsigned          PIX_W       = 8,
   parameter logic [PIX_W-1:0]     TRANSPARENT = '0
)
(
   input  logic          clk,
   input  logic          rst,
   sprite_blit_if.slave  bus
);
   state_t            state;
   pix_cnt_t          counter;
   pixel_addr_t       coord_q;
   logic [ID_W-1:0]   id_q;
   logic [ID_W+5:0]   rom_addr_q;
   pixel_addr_t       fb_addr_q;
   logic [PIX_W-1:0]  fb_data_q;
   logic              fb_we_q;
   logic              busy_q;
   logic              done_q;

   pixel_addr_t       pix_addr;
   pixel_addr_t       row_off;
   logic              skip;
   logic              last;

   sprite_addr u_addr (
      .coordinates (coord_q),
      .counter     (counter),
      .addr        (pix_addr),
      .row_off     (row_off)
   );

   // Skip decision is taken in FETCH, where rom_data for the current pixel is valid.
`ifdef SPRITE_BLIT_TRANSPARENCY_EN
   always_comb begin
      skip = (coord_q < row_off) || (bus.rom_data == TRANSPARENT);
   end
`else
   logic unused_transparent;
   always_comb begin
      skip               = (coord_q < row_off);
      unused_transparent = ^TRANSPARENT;
   end
`endif

   always_comb begin
      last = (counter == pix_cnt_t'(SPRITE_PIX - 1));
   end

   // rom_addr is loaded one state ahead so the pixel is ready at the end of FETCH;
   // fb_we only set for pixels to be written, so a skipped pixel leaves WRITE at once.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= IDLE;
         counter    <= '0;
         coord_q    <= '0;
         id_q       <= '0;
         rom_addr_q <= '0;
         fb_addr_q  <= '0;
         fb_data_q  <= '0;
         fb_we_q    <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (bus.start) begin
                  coord_q    <= bus.coordinates;
                  id_q       <= bus.sprite_id;
                  counter    <= '0;
                  rom_addr_q <= {bus.sprite_id, 6'd0};
                  busy_q     <= 1'b1;
                  state      <= FETCH;
               end
            end
            FETCH: begin
               fb_addr_q <= pix_addr;
               fb_data_q <= bus.rom_data;
               fb_we_q   <= !skip;
               state     <= WRITE;
            end
            WRITE: begin
               if (!fb_we_q || bus.fb_ready) begin
                  fb_we_q <= 1'b0;
                  if (last) begin
                     done_q <= 1'b1;
                     state  <= DONE;
                  end else begin
                     counter    <= counter + 6'd1;
                     rom_addr_q <= {id_q, counter + 6'd1};
                     state      <= FETCH;
                  end
               end
            end
            DONE: begin
               done_q <= 1'b0;
               busy_q <= 1'b0;
               state  <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   always_comb begin
      bus.busy     = busy_q;
      bus.done     = done_q;
      bus.rom_addr = rom_addr_q;
      bus.fb_addr  = fb_addr_q;
      bus.fb_data  = fb_data_q;
      bus.fb_we    = fb_we_q;
   end
endmodule
